// File: rtl/player_input_cond_pkg.sv
// rtl/player_input_cond_pkg.sv - shared channel indices and default limits for input conditioning
package player_input_cond_pkg;

  localparam int CH_COIN  = 0;
  localparam int CH_START = 1;
  localparam int CH_THROW = 2;
  localparam int NUM_CH   = 3;

  // About 10 ms of stable input at 6 MHz before a level change is accepted
  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd60000;

  localparam int DEF_MAX_CREDITS = 9;

  typedef logic [NUM_CH-1:0] ch_vec_t;

endpackage

// File: rtl/player_input_cond_if.sv
// rtl/player_input_cond_if.sv - cabinet-side raw inputs and conditioned outputs of the input block
interface player_input_cond_if #(
  parameter int CREDIT_W = 4
);

  logic                coin_n;
  logic                start_n;
  logic                throw_n;
  logic                auto_coin_n;
  logic                auto_start_n;
  logic                auto_throw_n;
  logic                coin_lvl_n;
  logic                start_lvl_n;
  logic                throw_lvl_n;
  logic                coin_pulse;
  logic                throw_pulse;
  logic                start_ok;
  logic [CREDIT_W-1:0] credits;

  // Cabinet / stimulus side: drives raw switches, observes conditioned results
  modport master (
    output coin_n, start_n, throw_n, auto_coin_n, auto_start_n, auto_throw_n,
    input  coin_lvl_n, start_lvl_n, throw_lvl_n, coin_pulse, throw_pulse, start_ok, credits
  );

  // Conditioning block side
  modport slave (
    input  coin_n, start_n, throw_n, auto_coin_n, auto_start_n, auto_throw_n,
    output coin_lvl_n, start_lvl_n, throw_lvl_n, coin_pulse, throw_pulse, start_ok, credits
  );

endinterface

// File: rtl/player_input_cond_input_debounce.sv
// rtl/player_input_cond_input_debounce.sv - per-channel synchronizer, debounce counter, level and press pulse
module input_debounce
  import player_input_cond_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_n_i,
  output logic lvl_n_o,
  output logic press_o,
  output logic pulse_o
);

  logic [1:0]  sync_q;
  logic        lvl_q;
  logic        lvl_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        pulse_q;
  logic        press;
  logic        s;

  assign s = sync_q[1];

  // Two-flop synchronizer; released (high) after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], raw_n_i};
    end
  end

  // Any sample equal to the held level restarts the count, so a glitch earns no partial credit
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    press = 1'b0;
    if (s == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      lvl_d = s;
      cnt_d = '0;
      press = ~s;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Held level, counter and the registered one-cycle press pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      pulse_q <= press;
    end
  end

  assign lvl_n_o = lvl_q;
  assign press_o = press;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/player_input_cond.sv
// rtl/player_input_cond.sv - coin/start/throw conditioning and credit counter (AUTO_MERGE_EN merges auto_* stimulus)
module player_input_cond
  import player_input_cond_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int          CREDIT_W        = 4,
  parameter int          MAX_CREDITS     = DEF_MAX_CREDITS
) (
  input logic                clk6m,
  input logic                reset_n,
  player_input_cond_if.slave pins
);

  localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

  ch_vec_t raw_n;
  ch_vec_t lvl_n;
  ch_vec_t press;
  ch_vec_t pulse;

  logic [CREDIT_W-1:0] credits_q;
  logic [CREDIT_W-1:0] credits_d;
  logic                start_ok_q;
  logic                start_ok_d;

`ifdef AUTO_MERGE_EN
  assign raw_n[CH_COIN]  = pins.coin_n  & pins.auto_coin_n;
  assign raw_n[CH_START] = pins.start_n & pins.auto_start_n;
  assign raw_n[CH_THROW] = pins.throw_n & pins.auto_throw_n;
`else
  assign raw_n[CH_COIN]  = pins.coin_n;
  assign raw_n[CH_START] = pins.start_n;
  assign raw_n[CH_THROW] = pins.throw_n;

  logic unused_auto;
  assign unused_auto = &{pins.auto_coin_n, pins.auto_start_n, pins.auto_throw_n};
`endif

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i   (clk6m),
      .rst_ni  (reset_n),
      .raw_n_i (raw_n[ch]),
      .lvl_n_o (lvl_n[ch]),
      .press_o (press[ch]),
      .pulse_o (pulse[ch])
    );
  end

  // Throw press and start pulse are not consumed here; game logic sees throw via its pulse
  logic unused_ev;
  assign unused_ev = ^{press[CH_THROW], pulse[CH_START]};

  // Coin is applied before start so a same-cycle coin can fund the start
  always_comb begin
    credits_d  = credits_q;
    start_ok_d = 1'b0;
    if (press[CH_COIN] && (credits_q < MAX_C)) begin
      credits_d = credits_q + 1'b1;
    end
    if (press[CH_START] && (credits_d != '0)) begin
      credits_d  = credits_d - 1'b1;
      start_ok_d = 1'b1;
    end
  end

  // Credit count and start acceptance, updated on the same edge as the press pulses
  always_ff @(posedge clk6m or negedge reset_n) begin
    if (!reset_n) begin
      credits_q  <= '0;
      start_ok_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      start_ok_q <= start_ok_d;
    end
  end

  assign pins.coin_lvl_n  = lvl_n[CH_COIN];
  assign pins.start_lvl_n = lvl_n[CH_START];
  assign pins.throw_lvl_n = lvl_n[CH_THROW];
  assign pins.coin_pulse  = pulse[CH_COIN];
  assign pins.throw_pulse = pulse[CH_THROW];
  assign pins.start_ok    = start_ok_q;
  assign pins.credits     = credits_q;

endmodule

// File: doc/player_input_cond.md
Name: player_input_cond

Overview:
- Conditions the player and cabinet inputs that arrive active-low and asynchronous to clk6m: coin, start and throw.
- Includes the auto_coin_n, auto_start_n and auto_throw_n stimulus lines driven by the clock/reset block.
- Synchronizes and debounces each channel, then emits clean levels and one-cycle press pulses.
- Maintains a saturating credit counter: coins add credits, start presses consume them. Game logic sees only the outputs of this block.

Parameters:
- DEBOUNCE_CYCLES, 16'd60000, number of consecutive stable synchronized samples needed before a level change is accepted (about 10 ms at 6 MHz).
- CREDIT_W, 4, width of the credit counter.
- MAX_CREDITS, 9, saturation value of the credit counter.

Ports:
- clk6m  in  1  pixel/game clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- coin_n  in  1  raw coin switch, active-low, async.
- start_n  in  1  raw start button, active-low, async.
- throw_n  in  1  raw throw button, active-low, async.
- auto_coin_n  in  1  auto-stimulus coin, active-low.
- auto_start_n  in  1  auto-stimulus start, active-low.
- auto_throw_n  in  1  auto-stimulus throw, active-low.
- coin_lvl_n  out  1  debounced coin level.
- start_lvl_n  out  1  debounced start level.
- throw_lvl_n  out  1  debounced throw level.
- coin_pulse  out  1  one-cycle pulse on a debounced coin press.
- throw_pulse  out  1  one-cycle pulse on a debounced throw press.
- start_ok  out  1  one-cycle pulse: start accepted and one credit consumed.
- credits  out  CREDIT_W  current credit count.

Behaviour:
- Reset (async assert, sync release on clk6m):
  - Sync flops = 1, *_lvl_n = 1 (released), all pulses = 0, credits = 0, debounce counters = 0.
- Merge: each channel input = raw AND auto (the channel is active when either source is low); see Optional Feature.
- Sync: 2-flop synchronizer per channel, output s.
- Debounce per channel, with held level d and counter c:
  - If s == d: c <= 0.
  - Else if c == DEBOUNCE_CYCLES-1: d <= s and c <= 0.
  - Else c <= c+1.
  - Any glitch that returns s to d before the threshold clears c, so there is no partial credit.
- Latency from a stable input edge to the lvl change: 2 + DEBOUNCE_CYCLES clocks.
- Press pulse: asserted for exactly one cycle, registered in the same clock edge where d goes 1->0. Releases (0->1) produce no pulse. Holding a button produces exactly one pulse.
- Credits, evaluated each cycle with cp = coin press event and sp = start press event:
  - cp only: credits <= min(credits+1, MAX_CREDITS).
  - sp only with credits > 0: credits-1, start_ok = 1.
  - sp only with credits == 0: no change, start_ok = 0.
  - cp and sp in the same cycle: coin is applied first, then start. With credits == 0 the result is credits stays 0 and start_ok = 1. At MAX_CREDITS the result is MAX_CREDITS-1.
  - credits never wraps.
- start_ok and coin_pulse are registered, so they are aligned with the credits update.
- Reset asserted mid-debounce or mid-pulse: state is cleared immediately. After release, a held button is seen as a fresh press once it has been stable for the full debounce time.

Optional Feature:
- Macro AUTO_MERGE_EN.
- Defined: the auto_* ports are ANDed into their channels as described above.
- Undefined: the auto_* ports are ignored (may be left unconnected) and each channel uses only its raw input. Credit and debounce behaviour are otherwise identical.

Decomposition:
- Shared package/include holds:
  - channel index localparams: CH_COIN=0, CH_START=1, CH_THROW=2;
  - the default DEBOUNCE_CYCLES;
  - MAX_CREDITS.
- One natural sub-module, input_debounce:
  - contains the synchronizer, debounce counter, level register and press pulse;
  - parameterized by DEBOUNCE_CYCLES;
  - instantiated 3x.
- Credit logic lives in the top level.

Test Plan (DEBOUNCE_CYCLES=4, MAX_CREDITS=9):
- Drive coin_n low and hold for 20 clocks -> coin_lvl_n falls at clock 6, one coin_pulse, credits 0->1.
- Toggle throw_n low for 3 clocks then high -> no level change, throw_pulse never asserted.
- Apply 11 coin presses with full releases -> credits saturates at 9, with no wrap.
- credits=0: press start -> start_ok stays 0, credits stays 0. Then 1 coin plus 1 start -> start_ok once, credits back to 0.
- Coin and start debounced in the same cycle:
  - with credits=0 -> start_ok=1, credits=0;
  - with credits=9 -> credits=8.
- With AUTO_MERGE_EN, pulse auto_throw_n low for 10 clocks while throw_n is high -> one throw_pulse. Without the macro, the same stimulus gives no pulse.
- Assert reset_n low mid-debounce of a held start -> all outputs return to reset values immediately. After release, start_lvl_n falls 6 clocks later.
